snn_pattern_feeder: RTL and testbench



---
 rtl/snn_pattern_feeder_pkg.sv | 21 ++
 rtl/snn_pattern_buf.sv | 48 ++++
 rtl/snn_pattern_feeder.sv | 145 ++++++++++++++
 tb/tb_snn_pattern_feeder.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pattern_feeder_pkg.sv
// Shared constants and types for the SNN pattern feeder.
// Pattern layout: weights, kernel, then two 6x6 images.
package snn_pattern_feeder_pkg;

  localparam int W_LEN   = 4;
  localparam int K_LEN   = 9;
  localparam int I_LEN   = 72;
  localparam int PAT_LEN = W_LEN + K_LEN + I_LEN;

  localparam logic [6:0] K_OFF     = 7'd4;
  localparam logic [6:0] I_OFF     = 7'd13;
  localparam logic [6:0] LAST_BYTE = 7'(PAT_LEN - 1);
  localparam logic [6:0] LAST_BEAT = 7'(I_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    WAIT
  } state_t;

endpackage

// File: rtl/snn_pattern_buf.sv
// Pattern storage: byte-indexed write port, beat-indexed read port.
// The read port slices one beat of img/ker/weight out of the pattern.
module snn_pattern_buf
  import snn_pattern_feeder_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [6:0] idx,
  input  logic [7:0] data,
  input  logic [6:0] beat,
  output logic [7:0] img,
  output logic [7:0] ker,
  output logic [7:0] weight
);

  logic [7:0] mem [PAT_LEN];
  logic [6:0] i_idx;
  logic [6:0] k_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PAT_LEN; i++) begin
        mem[i] <= '0;
      end
    end else if (we && idx <= LAST_BYTE) begin
      mem[idx] <= data;
    end
  end

  always_comb begin
    i_idx  = I_OFF + beat;
    k_idx  = K_OFF + beat;
    img    = '0;
    ker    = '0;
    weight = '0;
    if (beat <= LAST_BEAT) begin
      img = mem[i_idx];
    end
    if (beat < 7'(K_LEN)) begin
      ker = mem[k_idx];
    end
    if (beat < 7'(W_LEN)) begin
      weight = mem[beat];
    end
  end

endmodule

// File: rtl/snn_pattern_feeder.sv
// Feeder stage: buffers one pattern, streams a 72-beat burst to the
// SNN core, then captures its result (or a timeout) in a held slot.
module snn_pattern_feeder
  import snn_pattern_feeder_pkg::*;
#(
  parameter int TIMEOUT = 96
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       src_valid,
  output logic       src_ready,
  input  logic [7:0] src_data,
  output logic       in_valid,
  output logic [7:0] img,
  output logic [7:0] ker,
  output logic [7:0] weight,
  input  logic       core_out_valid,
  input  logic [9:0] core_out_data,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [9:0] res_data,
  output logic       res_err,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  state_t        state;
  logic [6:0]    load_cnt;
  logic [6:0]    beat;
  logic [TW-1:0] tcnt;
  logic          buf_full;
  logic          run_en;
  logic          accept;
  logic          pop;
  logic          last_beat;
  logic [7:0]    rd_img;
  logic [7:0]    rd_ker;
  logic [7:0]    rd_weight;

  // run_en keeps src_ready low while reset is asserted
  assign src_ready = run_en && !buf_full && state != STREAM;
  assign accept    = src_valid && src_ready;
  assign pop       = res_valid && res_ready;
  assign last_beat = state == STREAM && beat == LAST_BEAT;
  assign busy      = state != IDLE;

  snn_pattern_buf u_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (accept),
    .idx    (load_cnt),
    .data   (src_data),
    .beat   (beat),
    .img    (rd_img),
    .ker    (rd_ker),
    .weight (rd_weight)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_en   <= 1'b0;
      load_cnt <= '0;
      buf_full <= 1'b0;
    end else begin
      run_en <= 1'b1;
      if (accept) begin
        if (load_cnt == LAST_BYTE) begin
          load_cnt <= '0;
          buf_full <= 1'b1;
        end else begin
          load_cnt <= load_cnt + 7'd1;
        end
      end else if (last_beat) begin
        buf_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      beat      <= '0;
      tcnt      <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_err   <= 1'b0;
    end else begin
      if (pop) begin
        res_valid <= 1'b0;
        res_data  <= '0;
        res_err   <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (buf_full && !res_valid) begin
            state <= STREAM;
            beat  <= '0;
          end
        end
        STREAM: begin
          if (last_beat) begin
            state <= WAIT;
            tcnt  <= '0;
          end else begin
            beat <= beat + 7'd1;
          end
        end
        WAIT: begin
          if (core_out_valid) begin
            res_valid <= 1'b1;
            res_data  <= core_out_data;
            res_err   <= 1'b0;
            state     <= IDLE;
          end else if (tcnt == TMAX) begin
            res_valid <= 1'b1;
            res_data  <= '0;
            res_err   <= 1'b1;
            state     <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs trail the STREAM state by one cycle so they come from flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_valid <= 1'b0;
      img      <= '0;
      ker      <= '0;
      weight   <= '0;
    end else begin
      in_valid <= state == STREAM;
      img      <= state == STREAM ? rd_img : '0;
      ker      <= state == STREAM ? rd_ker : '0;
      weight   <= state == STREAM ? rd_weight : '0;
    end
  end

endmodule

// File: tb/tb_snn_pattern_feeder.sv
// Scoreboard bench for snn_pattern_feeder with a behavioural core model.
// Expected beats/results are queued at stimulus time, popped by monitors.
`timescale 1ns/1ps
module tb_snn_pattern_feeder;

  localparam int W_LEN   = 4;
  localparam int K_LEN   = 9;
  localparam int I_LEN   = 72;
  localparam int PAT_LEN = 85;
  localparam int TIMEOUT = 96;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       src_valid = 1'b0;
  logic       src_ready;
  logic [7:0] src_data = '0;
  logic       in_valid;
  logic [7:0] img;
  logic [7:0] ker;
  logic [7:0] weight;
  logic       core_out_valid = 1'b0;
  logic [9:0] core_out_data = '0;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [9:0] res_data;
  logic       res_err;
  logic       busy;

  snn_pattern_feeder #(.TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .src_valid      (src_valid),
    .src_ready      (src_ready),
    .src_data       (src_data),
    .in_valid       (in_valid),
    .img            (img),
    .ker            (ker),
    .weight         (weight),
    .core_out_valid (core_out_valid),
    .core_out_data  (core_out_data),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_data       (res_data),
    .res_err        (res_err),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] img;
    logic [7:0] ker;
    logic [7:0] weight;
  } beat_t;

  typedef struct {
    logic [9:0] data;
    logic       err;
    int         due;
  } res_t;

  beat_t      exp_beat[$];
  res_t       exp_res[$];
  logic [7:0] pat [PAT_LEN];

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   run = 0;
  int   bursts = 0;
  int   beat0_cyc = 0;
  int   last_beat_cyc = 0;
  int   pop_edge_cyc = -100;
  bit   aborting = 0;
  bit   rand_ready = 0;
  int   core_mode = 1;
  int   core_lat = 74;
  logic [9:0] core_data = '0;
  int   cd = 0;
  logic [9:0] cd_data = '0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act,
                           input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  always @(posedge clk) cyc++;

  // Core model: strobes a result some cycles after beat 0
  logic core_prev = 1'b0;
  always @(negedge clk) begin
    res_t r;
    int   l;
    core_out_valid = 1'b0;
    core_out_data  = '0;
    if (!rst_n) begin
      cd = 0;
    end else if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        core_out_valid = 1'b1;
        core_out_data  = cd_data;
      end
    end
    if (rst_n && in_valid && !core_prev) begin
      if (core_mode == 2) begin
        cd      = 200;
        cd_data = 10'h2aa;
        r.data  = '0;
        r.err   = 1'b1;
        r.due   = cyc + I_LEN - 1 + TIMEOUT;
      end else begin
        l       = core_mode == 3 ? $urandom_range(74, 150) : core_lat;
        cd_data = core_mode == 3 ? 10'($urandom) : core_data;
        cd      = l;
        r.data  = cd_data;
        r.err   = 1'b0;
        r.due   = cyc + l + 1;
      end
      exp_res.push_back(r);
    end
    core_prev = in_valid;
  end

  // Burst monitor
  always @(negedge clk) begin
    beat_t e;
    if (in_valid) begin
      if (run == 0) beat0_cyc = cyc;
      chk("beat_expected", int'(exp_beat.size() != 0), 1);
      if (exp_beat.size() != 0) begin
        e = exp_beat.pop_front();
        chk($sformatf("img[%0d]", run), int'(img), int'(e.img));
        chk($sformatf("ker[%0d]", run), int'(ker), int'(e.ker));
        chk($sformatf("weight[%0d]", run), int'(weight), int'(e.weight));
      end
      run++;
      last_beat_cyc = cyc;
    end else begin
      chk("idle_zero", int'({img, ker, weight}), 0);
      if (run != 0) begin
        if (!aborting) chk("burst_len", run, I_LEN);
        bursts++;
        run = 0;
      end
    end
  end

  // Result monitor
  logic       rv_prev = 1'b0;
  bit         pop_prev = 0;
  logic [9:0] hd = '0;
  logic       he = 1'b0;
  always @(negedge clk) begin
    res_t e;
    if (pop_prev) chk("res_clear", int'(res_valid), 0);
    if (res_valid && (!rv_prev || pop_prev)) begin
      chk("res_expected", int'(exp_res.size() != 0), 1);
      if (exp_res.size() != 0) begin
        e = exp_res.pop_front();
        chk("res_data", int'(res_data), int'(e.data));
        chk("res_err", int'(res_err), int'(e.err));
        if (e.err)
          chk_range("timeout_lat", cyc - last_beat_cyc, TIMEOUT - 1, TIMEOUT + 1);
        else
          chk("res_time", cyc, e.due);
      end
    end else if (res_valid) begin
      chk("res_hold", int'({res_data, res_err}), int'({hd, he}));
    end
    hd       = res_data;
    he       = res_err;
    rv_prev  = res_valid;
    pop_prev = res_valid && res_ready;
    if (pop_prev) pop_edge_cyc = cyc + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_pat();
    for (int i = 0; i < PAT_LEN; i++) pat[i] = 8'($urandom);
  endtask

  task automatic load(input int gap);
    int    n = 0;
    int    guard = 0;
    beat_t b;
    for (int k = 0; k < I_LEN; k++) begin
      b.img    = pat[13 + k];
      b.ker    = k < K_LEN ? pat[4 + k] : 8'd0;
      b.weight = k < W_LEN ? pat[k] : 8'd0;
      exp_beat.push_back(b);
    end
    while (n < PAT_LEN && guard < 4000) begin
      tick();
      guard++;
      if ($urandom_range(0, 99) < gap) begin
        src_valid = 1'b0;
      end else begin
        src_valid = 1'b1;
        src_data  = pat[n];
      end
      if (src_valid && src_ready) n++;
    end
    tick();
    src_valid = 1'b0;
    chk("load_count", n, PAT_LEN);
    chk("src_ready_full", int'(src_ready), 0);
  endtask

  task automatic wait_done();
    int t = 0;
    while (t < 3000 && !(exp_beat.size() == 0 && exp_res.size() == 0 &&
           !busy && !res_valid && run == 0 && cd == 0)) begin
      tick();
      t++;
      if (rand_ready) res_ready = 1'($urandom_range(0, 1));
    end
    chk("drain_in_time", int'(t < 3000), 1);
  endtask

  task automatic wait_res();
    int t = 0;
    while (t < 1000 && !res_valid) begin
      tick();
      t++;
    end
    chk("res_in_time", int'(res_valid), 1);
  endtask

  task automatic wait_bursts(input int target);
    int t = 0;
    while (t < 1000 && bursts < target) begin
      tick();
      t++;
    end
    chk("burst_in_time", int'(bursts >= target), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int b0;
    repeat (3) tick();
    chk("rst_in_valid", int'(in_valid), 0);
    chk("rst_src_ready", int'(src_ready), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_data", int'({res_data, res_err}), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    repeat (2) tick();
    chk("src_ready_after_rst", int'(src_ready), 1);

    // Counting pattern, continuous source
    for (int i = 0; i < PAT_LEN; i++) pat[i] = 8'(i + 1);
    core_mode = 1;
    core_lat  = 74;
    core_data = 10'd500;
    res_ready = 1'b1;
    load(0);
    wait_done();

    // Same pattern, gappy source
    core_data = 10'd801;
    load(50);
    wait_done();

    // Result held for 20 cycles with consumer stalled
    rand_pat();
    core_data = 10'd37;
    res_ready = 1'b0;
    load(0);
    wait_res();
    repeat (20) tick();
    chk("res_still_held", int'(res_valid), 1);
    res_ready = 1'b1;
    tick();
    wait_done();

    // Next pattern loaded while the result slot is full
    res_ready = 1'b0;
    rand_pat();
    b0 = bursts;
    load(0);
    wait_bursts(b0 + 1);
    rand_pat();
    load(30);
    repeat (10) begin
      tick();
      chk("no_burst_while_held", int'(in_valid), 0);
    end
    chk("slot_full_before_pop", int'(res_valid), 1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    wait_bursts(b0 + 2);
    chk("pop_to_beat0", beat0_cyc - pop_edge_cyc, 2);
    res_ready = 1'b1;
    wait_done();

    // Timeout, then a late strobe that must be ignored
    core_mode = 2;
    res_ready = 1'b0;
    rand_pat();
    load(20);
    wait_res();
    chk("busy_after_timeout", int'(busy), 0);
    repeat (50) tick();
    res_ready = 1'b1;
    wait_done();

    // Asynchronous reset in the middle of a burst
    core_mode = 1;
    rand_pat();
    load(0);
    t = 0;
    while (t < 1000 && run < 30) begin
      tick();
      t++;
    end
    chk("reached_beat30", int'(run >= 30), 1);
    aborting = 1;
    rst_n = 1'b0;
    #1;
    chk("async_drop", int'(in_valid), 0);
    chk("async_busy", int'(busy), 0);
    exp_beat.delete();
    exp_res.delete();
    #20;
    rst_n = 1'b1;
    repeat (3) tick();
    chk("src_ready_after_abort", int'(src_ready), 1);
    aborting = 0;
    rand_pat();
    load(0);
    wait_done();

    // Random patterns, latencies and consumer stalls
    core_mode  = 3;
    rand_ready = 1;
    for (int r = 0; r < 4; r++) begin
      rand_pat();
      load($urandom_range(0, 60));
      wait_done();
    end
    rand_ready = 0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
